// File: rtl/acap_mailbox_host_pkg.sv
// Shared mailbox constants and host FSM encoding for the AddToACAP port-A sequencer.
// Reused by the accumulator side and the benches so both agree on the mailbox map.
package acap_mailbox_host_pkg;

    localparam int unsigned MBX_RING_SIZE   = 1024;
    localparam int unsigned MBX_LOAD_WORDS  = 4096;
    localparam logic [31:0] MBX_LOAD_BASE   = 32'h0000_0000;
    localparam logic [31:0] MBX_START_ADDR  = 32'h0000_1004;
    localparam logic [31:0] MBX_DONE_ADDR   = 32'h0000_1789;
    localparam logic [31:0] MBX_RESULT_BASE = 32'h0000_1800;
    localparam logic [31:0] MBX_START_MAGIC = 32'hDEAD_BEEF;
    localparam logic [31:0] MBX_DONE_MAGIC  = 32'hD01E_CAFE;
    localparam int unsigned MBX_POLL_GAP    = 16;
    localparam int unsigned MBX_TIMEOUT     = 2000000;
    localparam int unsigned MBX_FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_POLL,
        ST_CLR,
        ST_READ
    } mbx_state_e;

endpackage

// File: rtl/mbx_skid_fifo.sv
// Small synchronous FIFO buffering result words between BRAM reads and the m_* stream.
// Exposes its occupancy so the reader can account for reads still in flight.
module mbx_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // The reader's credit scheme must never push into a full FIFO without a pop.
    assert property (@(posedge clk_i) disable iff (!resetn_i) !(push_i && full && !pop_i));

endmodule

// File: rtl/acap_mailbox_host.sv
// Port-A host sequencer for the AddToACAP mailbox BRAM: load input, kick, poll done,
// clear the done flag and stream the 2*RING_SIZE result words out through a skid FIFO.
module acap_mailbox_host
    import acap_mailbox_host_pkg::*;
#(
    parameter int unsigned RING_SIZE   = MBX_RING_SIZE,
    parameter int unsigned LOAD_WORDS  = MBX_LOAD_WORDS,
    parameter logic [31:0] LOAD_BASE   = MBX_LOAD_BASE,
    parameter logic [31:0] START_ADDR  = MBX_START_ADDR,
    parameter logic [31:0] DONE_ADDR   = MBX_DONE_ADDR,
    parameter logic [31:0] RESULT_BASE = MBX_RESULT_BASE,
    parameter logic [31:0] START_MAGIC = MBX_START_MAGIC,
    parameter logic [31:0] DONE_MAGIC  = MBX_DONE_MAGIC,
    parameter int unsigned POLL_GAP    = MBX_POLL_GAP,
    parameter int unsigned TIMEOUT     = MBX_TIMEOUT,
    parameter int unsigned FIFO_DEPTH  = MBX_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        cmd_start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    input  logic [31:0] s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [31:0] m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        m_last_o,
    output logic [31:0] bram_addr_o,
    output logic [31:0] bram_wdata_o,
    output logic [3:0]  bram_we_o,
    output logic        bram_en_o,
    input  logic [31:0] bram_rdata_i
);
    localparam int unsigned RESULT_WORDS = 2 * RING_SIZE;
    localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1;

    mbx_state_e  state_q;
    logic [31:0] ld_cnt_q;
    logic [31:0] rd_cnt_q;
    logic [31:0] out_cnt_q;
    logic [31:0] gap_q;
    logic [31:0] tmo_q;
    logic [1:0]  rd_pipe_q;
    logic [1:0]  poll_pipe_q;
    logic        error_q;
    logic        done_q;
    logic [31:0] bram_addr_q;
    logic [31:0] bram_wdata_q;
    logic [3:0]  bram_we_q;
    logic        bram_en_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          pop;
    logic          last_word;
    logic [31:0]   occupancy;
    logic          can_issue;

    assign busy_o       = (state_q != ST_IDLE);
    assign s_ready_o    = (state_q == ST_LOAD);
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign bram_addr_o  = bram_addr_q;
    assign bram_wdata_o = bram_wdata_q;
    assign bram_we_o    = bram_we_q;
    assign bram_en_o    = bram_en_q;

    assign m_valid_o = !fifo_empty;
    assign pop       = m_valid_o && m_ready_i;
    assign last_word = (out_cnt_q == 32'(RESULT_WORDS - 1));
    assign m_last_o  = m_valid_o && last_word;

    // Reads already issued occupy FIFO slots before their data arrives two edges later.
    assign occupancy = 32'(fifo_count) + 32'(rd_pipe_q[0]) + 32'(rd_pipe_q[1]);
    assign can_issue = (state_q == ST_READ) && (rd_cnt_q < RESULT_WORDS) && (occupancy < FIFO_DEPTH);

    mbx_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push_i   (rd_pipe_q[1]),
        .data_i   (bram_rdata_i),
        .pop_i    (pop),
        .data_o   (m_data_o),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= ST_IDLE;
            ld_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            out_cnt_q    <= '0;
            gap_q        <= '0;
            tmo_q        <= '0;
            rd_pipe_q    <= '0;
            poll_pipe_q  <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            bram_we_q    <= '0;
            bram_en_q    <= 1'b0;
        end else begin
            bram_en_q   <= 1'b0;
            bram_we_q   <= 4'b0000;
            done_q      <= 1'b0;
            rd_pipe_q   <= {rd_pipe_q[0], can_issue};
            poll_pipe_q <= {poll_pipe_q[0], 1'b0};
            if (pop) out_cnt_q <= out_cnt_q + 32'd1;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_start_i) begin
                        state_q  <= ST_LOAD;
                        error_q  <= 1'b0;
                        ld_cnt_q <= '0;
                    end
                end
                ST_LOAD: begin
                    if (s_valid_i) begin
                        bram_en_q    <= 1'b1;
                        bram_we_q    <= 4'b1111;
                        bram_addr_q  <= LOAD_BASE + ld_cnt_q;
                        bram_wdata_q <= s_data_i;
                        ld_cnt_q     <= ld_cnt_q + 32'd1;
                        if (ld_cnt_q == LOAD_WORDS - 1) state_q <= ST_KICK;
                    end
                end
                ST_KICK: begin
                    bram_en_q    <= 1'b1;
                    bram_we_q    <= 4'b1111;
                    bram_addr_q  <= START_ADDR;
                    bram_wdata_q <= START_MAGIC;
                    gap_q        <= '0;
                    tmo_q        <= '0;
                    state_q      <= ST_POLL;
                end
                ST_POLL: begin
                    tmo_q <= tmo_q + 32'd1;
                    if (gap_q == '0) begin
                        bram_en_q   <= 1'b1;
                        bram_addr_q <= DONE_ADDR;
                        gap_q       <= POLL_GAP - 1;
                        poll_pipe_q <= {poll_pipe_q[0], 1'b1};
                    end else begin
                        gap_q <= gap_q - 32'd1;
                    end
                    if (poll_pipe_q[1] && (bram_rdata_i == DONE_MAGIC)) begin
                        state_q <= ST_CLR;
                    end else if (tmo_q == TIMEOUT - 1) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    bram_en_q    <= 1'b1;
                    bram_we_q    <= 4'b1111;
                    bram_addr_q  <= DONE_ADDR;
                    bram_wdata_q <= 32'h0;
                    rd_cnt_q     <= '0;
                    out_cnt_q    <= '0;
                    state_q      <= ST_READ;
                end
                ST_READ: begin
                    if (can_issue) begin
                        bram_en_q   <= 1'b1;
                        bram_addr_q <= RESULT_BASE + rd_cnt_q;
                        rd_cnt_q    <= rd_cnt_q + 32'd1;
                    end
                    if (pop && last_word) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acap_mailbox_host.sv
// Scoreboard bench for acap_mailbox_host with a behavioural 8K-word mailbox BRAM
// and a simple accumulator model that raises the done word 500 cycles after the kick.
module tb_acap_mailbox_host;

    localparam int unsigned RS      = 1024;
    localparam int unsigned LW      = 8;
    localparam int unsigned TO      = 1000;
    localparam int unsigned PG      = 16;
    localparam int unsigned NRES    = 2 * RS;
    localparam logic [31:0] START_A = 32'h0000_1004;
    localparam logic [31:0] DONE_A  = 32'h0000_1789;
    localparam logic [31:0] RES_A   = 32'h0000_1800;
    localparam logic [31:0] START_M = 32'hDEAD_BEEF;
    localparam logic [31:0] DONE_M  = 32'hD01E_CAFE;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmdStart = 1'b0;
    logic [31:0] sData = '0;
    logic        sValid = 1'b0;
    logic        mReady = 1'b0;
    logic        busy, done, error, sReady, mValid, mLast, bramEn;
    logic [31:0] mData, bramAddr, bramWdata;
    logic [31:0] bramRdata = '0;
    logic [3:0]  bramWe;

    int errors = 0;
    int checks = 0;

    acap_mailbox_host #(
        .RING_SIZE  (RS),
        .LOAD_WORDS (LW),
        .POLL_GAP   (PG),
        .TIMEOUT    (TO),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .cmd_start_i  (cmdStart),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .s_data_i     (sData),
        .s_valid_i    (sValid),
        .s_ready_o    (sReady),
        .m_data_o     (mData),
        .m_valid_o    (mValid),
        .m_ready_i    (mReady),
        .m_last_o     (mLast),
        .bram_addr_o  (bramAddr),
        .bram_wdata_o (bramWdata),
        .bram_we_o    (bramWe),
        .bram_en_o    (bramEn),
        .bram_rdata_i (bramRdata)
    );

    always #5 clk = ~clk;

    // Mailbox BRAM: port A is the DUT, port B is the accumulator model.
    logic [31:0] mem [0:8191];
    logic [31:0] resultMem [0:NRES-1];
    logic [31:0] wrLog [$];
    bit          modelOn = 1'b0;
    int          cyc = 0;
    int          modelCount = 0;
    int          kickCyc = -1;
    int          doneWriteCyc = -1;
    int          firstPollCyc = -1;
    int          badWe = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (modelCount > 0) begin
            modelCount <= modelCount - 1;
            if (modelCount == 1) begin
                mem[13'(DONE_A)] <= DONE_M;
                doneWriteCyc     <= cyc;
            end
        end
        if (bramEn) begin
            if (bramWe == 4'hF) begin
                mem[bramAddr[12:0]] <= bramWdata;
                wrLog.push_back(bramAddr);
                if (bramAddr == START_A) begin
                    kickCyc      <= cyc;
                    doneWriteCyc <= -1;
                    firstPollCyc <= -1;
                    modelCount   <= modelOn ? 500 : 0;
                end
            end else if (bramWe == 4'h0) begin
                if (bramAddr >= RES_A && bramAddr < RES_A + NRES)
                    bramRdata <= resultMem[11'(bramAddr - RES_A)];
                else
                    bramRdata <= mem[bramAddr[12:0]];
                if (bramAddr == DONE_A && doneWriteCyc >= 0 && firstPollCyc < 0 && cyc > doneWriteCyc)
                    firstPollCyc <= cyc;
            end else begin
                badWe <= badWe + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard: expected words are queued when a run is issued and popped on every handshake.
    logic [31:0] expQ [$];
    bit          expLastQ [$];
    int          popCycQ [$];
    int          doneCycles = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (done) doneCycles++;
            if (mLast && !mValid) checkOutput("lastWithoutValid", 32'(mLast), 0);
            if (mValid && mReady) begin
                int pending;
                pending = expQ.size();
                popCycQ.push_back(cyc);
                checkOutput("scoreboardHasWord", 32'(pending > 0), 1);
                if (pending > 0) begin
                    logic [31:0] expWord;
                    bit          expLast;
                    expWord = expQ.pop_front();
                    expLast = expLastQ.pop_front();
                    checkOutput("resultWord", mData, expWord);
                    checkOutput("resultLast", 32'(mLast), 32'(expLast));
                end
            end
        end
    end

    logic [31:0] loadExp [0:LW-1];

    task automatic startCmd();
        cmdStart = 1'b1;
        @(posedge clk); #1;
        cmdStart = 1'b0;
    endtask

    task automatic feedWords(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            bit accepted;
            sData  = $urandom;
            sValid = 1'b1;
            loadExp[i % LW] = sData;
            accepted = 1'b0;
            for (int t = 0; t < 100 && !accepted; t++) begin
                @(negedge clk);
                accepted = sReady;
                @(posedge clk); #1;
            end
            if (!accepted) checkOutput("feedBound", 0, 1);
            if (toggle) begin
                sValid = 1'b0;
                @(posedge clk); #1;
            end
        end
        sValid = 1'b0;
    endtask

    int endCyc;

    task automatic applyStimulus(input bit toggle, input int readyPct, input bit modelEnable, input bit expectTimeout);
        int bound;
        modelOn = modelEnable;
        if (!expectTimeout) begin
            for (int j = 0; j < NRES; j++) begin
                resultMem[j] = $urandom;
                expQ.push_back(resultMem[j]);
                expLastQ.push_back(j == NRES - 1);
            end
        end
        mReady = 1'b0;
        startCmd();
        checkOutput("errorClearedOnStart", 32'(error), 0);
        feedWords(LW, toggle);
        bound = 0;
        while (busy && bound < 40000) begin
            @(posedge clk); #1;
            mReady = ($urandom_range(0, 99) < readyPct);
            bound++;
        end
        endCyc = cyc;
        checkOutput("runCompletes", 32'(busy), 0);
        mReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wrBase, popBase, doneBase;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstError", 32'(error), 0);
        checkOutput("rstSReady", 32'(sReady), 0);
        checkOutput("rstMValid", 32'(mValid), 0);
        checkOutput("rstMLast", 32'(mLast), 0);
        checkOutput("rstBramEn", 32'(bramEn), 0);
        checkOutput("rstBramWe", 32'(bramWe), 0);
        checkOutput("rstBramAddr", bramAddr, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] abort a load with reset");
        startCmd();
        feedWords(5, 1'b0);
        checkOutput("weBeforeReset", 32'(bramWe), 32'hF);
        resetn = 1'b0;
        #1;
        checkOutput("weAsyncDrop", 32'(bramWe), 0);
        checkOutput("busyAsyncDrop", 32'(busy), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        checkOutput("postResetBusy", 32'(busy), 0);
        checkOutput("postResetError", 32'(error), 0);

        $display("[TB] run A: toggling input, m_ready always high");
        wrBase = wrLog.size(); popBase = popCycQ.size(); doneBase = doneCycles;
        applyStimulus(1'b1, 100, 1'b1, 1'b0);
        checkOutput("runA_writeCount", 32'(wrLog.size() - wrBase), LW + 2);
        if (wrLog.size() - wrBase == LW + 2) begin
            for (int i = 0; i < LW; i++) checkOutput("runA_loadAddr", wrLog[wrBase + i], 32'(i));
            checkOutput("runA_kickAfterLoad", wrLog[wrBase + LW], START_A);
            checkOutput("runA_clrAfterKick", wrLog[wrBase + LW + 1], DONE_A);
        end
        for (int i = 0; i < LW; i++) checkOutput("runA_loadData", mem[i], loadExp[i]);
        checkOutput("runA_startMagic", mem[13'(START_A)], START_M);
        checkOutput("runA_doneCleared", mem[13'(DONE_A)], 0);
        checkOutput("runA_pollLatencyOk", 32'(firstPollCyc > doneWriteCyc && firstPollCyc - doneWriteCyc <= PG + 1), 1);
        checkOutput("runA_popCount", 32'(popCycQ.size() - popBase), NRES);
        if (popCycQ.size() - popBase == NRES)
            checkOutput("runA_throughput", 32'(popCycQ[popBase + NRES - 1] - popCycQ[popBase]), NRES - 1);
        checkOutput("runA_donePulse", 32'(doneCycles - doneBase), 1);

        $display("[TB] run B: m_ready random at 30 percent");
        popBase = popCycQ.size(); doneBase = doneCycles;
        applyStimulus(1'b0, 30, 1'b1, 1'b0);
        for (int i = 0; i < LW; i++) checkOutput("runB_loadData", mem[i], loadExp[i]);
        checkOutput("runB_popCount", 32'(popCycQ.size() - popBase), NRES);
        checkOutput("runB_donePulse", 32'(doneCycles - doneBase), 1);

        $display("[TB] run C: accumulator never answers");
        doneBase = doneCycles;
        applyStimulus(1'b0, 100, 1'b0, 1'b1);
        checkOutput("runC_error", 32'(error), 1);
        checkOutput("runC_noDone", 32'(doneCycles - doneBase), 0);
        checkOutput("runC_timeoutWindow", 32'((endCyc - kickCyc) >= int'(TO) - 5 && (endCyc - kickCyc) <= int'(TO) + 5), 1);

        $display("[TB] run D: recover after timeout");
        popBase = popCycQ.size(); doneBase = doneCycles;
        applyStimulus(1'b0, 60, 1'b1, 1'b0);
        checkOutput("runD_error", 32'(error), 0);
        checkOutput("runD_popCount", 32'(popCycQ.size() - popBase), NRES);
        checkOutput("runD_donePulse", 32'(doneCycles - doneBase), 1);

        checkOutput("scoreboardDrained", 32'(expQ.size()), 0);
        checkOutput("byteEnablesWhole", 32'(badWe), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
